// File: rtl/press_counter_display.sv
`default_nettype none
// ============================================================================
//  Module      : press_counter_display
//  Description : Counts button presses in two-digit BCD and drives two
//                seven-segment digits. A press held for HOLD_TIME consecutive
//                cycles in the pressed state clears the count instead of
//                incrementing it, and a one-cycle o_Cleared pulse follows.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD_TIME       pressed cycles that turn a press into a clear (2..2^25-1)
//  Ports
//    CLK             system clock, rising edge
//    i_Reset         asynchronous active-high reset
//    i_Button_State  debounced button level, 1 = pressed, synchronous to CLK
//    o_Count         press count, BCD: [7:4] tens, [3:0] ones
//    o_Segment1      tens digit, active-low segments, bit6 = A .. bit0 = G
//    o_Segment2      ones digit, same encoding as o_Segment1
//    o_Cleared       one-cycle pulse following a long-press clear
// ============================================================================
module press_counter_display #(
  parameter int HOLD_TIME = 25000000
) (
  input  logic       CLK,
  input  logic       i_Reset,
  input  logic       i_Button_State,
  output logic [7:0] o_Count,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2,
  output logic       o_Cleared
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_PRESSED = 2'd1;
  localparam logic [1:0]  c_HELD    = 2'd2;

  // Timer value seen in the last pressed cycle before a hold becomes a clear.
  localparam logic [24:0] c_HOLD_LAST = 25'(HOLD_TIME - 1);

  localparam logic [6:0]  c_SEG_BLANK = 7'h7F;
  localparam logic [6:0]  c_SEG_ZERO  = 7'h01;

  // --------------------------------------------------------------------------
  // Active-low segment decode, {A,B,C,D,E,F,G}. Non-BCD values blank the
  // digit; they cannot occur because the counter only ever steps in BCD.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h01;
      4'd1:    seg = 7'h4F;
      4'd2:    seg = 7'h12;
      4'd3:    seg = 7'h06;
      4'd4:    seg = 7'h4C;
      4'd5:    seg = 7'h24;
      4'd6:    seg = 7'h20;
      4'd7:    seg = 7'h0F;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h04;
      default: seg = c_SEG_BLANK;
    endcase
    return seg;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [24:0] r_timer;
  logic [7:0]  r_count;
  logic        r_cleared;
  logic [6:0]  r_seg1;
  logic [6:0]  r_seg2;

  // --------------------------------------------------------------------------
  // Combinational next-state values
  // --------------------------------------------------------------------------
  logic [1:0]  w_state_nxt;
  logic [24:0] w_timer_nxt;
  logic [7:0]  w_count_nxt;
  logic        w_cleared_nxt;
  logic [7:0]  w_count_inc;
  logic [3:0]  w_ones;
  logic [3:0]  w_tens;

  assign w_ones = r_count[3:0];
  assign w_tens = r_count[7:4];

  // BCD increment: ones wrap 9 -> 0 with carry; 99 wraps to 00.
  always_comb begin
    w_count_inc = r_count;
    if (w_ones == 4'd9) begin
      w_count_inc[3:0] = 4'd0;
      if (w_tens == 4'd9) begin
        w_count_inc[7:4] = 4'd0;
      end else begin
        w_count_inc[7:4] = w_tens + 4'd1;
      end
    end else begin
      w_count_inc[3:0] = w_ones + 4'd1;
    end
  end

  // Press FSM. In PRESSED the release test comes first so that a release in
  // the threshold cycle still counts as a short press.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_count_nxt   = r_count;
    w_cleared_nxt = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (i_Button_State) begin
          w_state_nxt = c_PRESSED;
          w_timer_nxt = 25'd0;
        end
      end
      c_PRESSED: begin
        if (!i_Button_State) begin
          w_count_nxt = w_count_inc;
          w_state_nxt = c_IDLE;
        end else if (r_timer == c_HOLD_LAST) begin
          w_count_nxt   = 8'h00;
          w_cleared_nxt = 1'b1;
          w_state_nxt   = c_HELD;
        end else begin
          w_timer_nxt = r_timer + 25'd1;
        end
      end
      c_HELD: begin
        // Long press already consumed; wait for release without counting.
        if (!i_Button_State) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_timer_nxt = 25'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, timer, count and clear pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      r_state   <= c_IDLE;
      r_timer   <= 25'd0;
      r_count   <= 8'h00;
      r_cleared <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_count   <= w_count_nxt;
      r_cleared <= w_cleared_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Segment registers: decode of the registered count, one cycle behind it.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge i_Reset) begin
    if (i_Reset) begin
      r_seg1 <= c_SEG_ZERO;
      r_seg2 <= c_SEG_ZERO;
    end else begin
      r_seg1 <= seg_decode(r_count[7:4]);
      r_seg2 <= seg_decode(r_count[3:0]);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_Count    = r_count;
  assign o_Segment1 = r_seg1;
  assign o_Segment2 = r_seg2;
  assign o_Cleared  = r_cleared;

endmodule
`default_nettype wire

// File: tb/tb_press_counter_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_press_counter_display
//  Description : Self-checking bench for press_counter_display (HOLD_TIME=8).
//                A reference model predicts the outputs after every clock edge
//                into a queue; a monitor pops and compares. Directed press
//                sequences are followed by randomized presses and resets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_press_counter_display;

  localparam int HOLD = 8;

  logic       CLK = 1'b0;
  logic       i_Reset;
  logic       i_Button_State;
  logic [7:0] o_Count;
  logic [6:0] o_Segment1;
  logic [6:0] o_Segment2;
  logic       o_Cleared;

  always #5 CLK = ~CLK;

  press_counter_display #(.HOLD_TIME(HOLD)) dut (
    .CLK            (CLK),
    .i_Reset        (i_Reset),
    .i_Button_State (i_Button_State),
    .o_Count        (o_Count),
    .o_Segment1     (o_Segment1),
    .o_Segment2     (o_Segment2),
    .o_Cleared      (o_Cleared)
  );

  typedef struct {
    logic [7:0] cnt;
    logic [6:0] s1;
    logic [6:0] s2;
    logic       clr;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] seg_tab [0:9] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

  int vectors     = 0;
  int miscompares = 0;
  int clr_cycles  = 0;

  // Model state: decimal count and number of consecutive high samples in the
  // current press (0 = no press in progress).
  int   m_cnt = 0;
  int   m_run = 0;
  exp_t m_e;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one prediction per rising edge.
  // A press is a run of high samples starting from rest. Sample number
  // HOLD+1 of a run clears the count; a release after 1..HOLD high samples
  // is a short press and adds one (mod 100).
  initial begin
    forever begin
      @(posedge CLK);
      if (i_Reset) begin
        m_cnt = 0;
        m_run = 0;
        m_e.cnt = 8'h00; m_e.s1 = 7'h01; m_e.s2 = 7'h01; m_e.clr = 1'b0;
      end else begin
        m_e.s1  = seg_tab[m_cnt / 10];
        m_e.s2  = seg_tab[m_cnt % 10];
        m_e.clr = 1'b0;
        if (i_Button_State) begin
          if (m_run <= HOLD) begin
            m_run++;
            if (m_run == HOLD + 1) begin
              m_cnt   = 0;
              m_e.clr = 1'b1;
            end
          end
        end else begin
          if (m_run >= 1 && m_run <= HOLD) m_cnt = (m_cnt + 1) % 100;
          m_run = 0;
        end
        m_e.cnt = to_bcd(m_cnt);
      end
      sb_q.push_back(m_e);
    end
  end

  // Monitor: compares DUT outputs 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: got no prediction, expected one at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (o_Cleared === 1'b1) clr_cycles++;
        chk("count",    o_Count,              e.cnt);
        chk("segment1", {1'b0, o_Segment1},   {1'b0, e.s1});
        chk("segment2", {1'b0, o_Segment2},   {1'b0, e.s2});
        chk("cleared",  {7'b0, o_Cleared},    {7'b0, e.clr});
      end
    end
  end

  task automatic press(input int hi, input int gap);
    @(negedge CLK);
    i_Button_State = 1'b1;
    repeat (hi) @(negedge CLK);
    i_Button_State = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic sync_reset_pulse();
    @(negedge CLK);
    i_Reset = 1'b1;
    repeat (2) @(negedge CLK);
    i_Reset = 1'b0;
  endtask

  initial begin
    int clr0;
    i_Reset        = 1'b1;
    i_Button_State = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_count", o_Count, 8'h00);
    chk("reset_seg1",  {1'b0, o_Segment1}, 8'h01);
    chk("reset_seg2",  {1'b0, o_Segment2}, 8'h01);
    i_Reset = 1'b0;

    // Three 2-cycle presses with 2-cycle gaps.
    clr0 = clr_cycles;
    repeat (3) press(2, 2);
    chk("p3_count", o_Count, 8'h03);
    chk("p3_seg1",  {1'b0, o_Segment1}, 8'h01);
    chk("p3_seg2",  {1'b0, o_Segment2}, 8'h06);
    chk("p3_noclr", 8'(clr_cycles - clr0), 8'd0);

    // 99 -> 00 wrap.
    sync_reset_pulse();
    repeat (99) press(1, 1);
    chk("pre99_count", o_Count, 8'h99);
    press(1, 2);
    chk("wrap_count", o_Count, 8'h00);
    chk("wrap_seg1",  {1'b0, o_Segment1}, 8'h01);
    chk("wrap_seg2",  {1'b0, o_Segment2}, 8'h01);

    // Long hold clears once, release adds nothing.
    sync_reset_pulse();
    repeat (5) press(1, 1);
    clr0 = clr_cycles;
    press(20, 3);
    chk("hold_count",  o_Count, 8'h00);
    chk("hold_pulses", 8'(clr_cycles - clr0), 8'd1);

    // Release in the threshold cycle wins over the clear.
    sync_reset_pulse();
    repeat (2) press(1, 1);
    clr0 = clr_cycles;
    press(HOLD, 3);
    chk("thr_count", o_Count, 8'h03);
    chk("thr_noclr", 8'(clr_cycles - clr0), 8'd0);

    // Asynchronous reset mid-press abandons the press.
    sync_reset_pulse();
    repeat (4) press(1, 1);
    chk("pre_arst_count", o_Count, 8'h04);
    @(negedge CLK);
    i_Button_State = 1'b1;
    repeat (3) @(negedge CLK);
    #2 i_Reset = 1'b1;
    #1 chk("arst_count", o_Count, 8'h00);
    chk("arst_clr", {7'b0, o_Cleared}, 8'h00);
    @(negedge CLK);
    i_Button_State = 1'b0;
    @(negedge CLK);
    i_Reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk("arst_after_release", o_Count, 8'h00);

    // One-cycle press: count leads the segment outputs by one cycle.
    @(negedge CLK);
    i_Button_State = 1'b1;
    @(negedge CLK);
    i_Button_State = 1'b0;
    @(negedge CLK);
    chk("lat_count",    o_Count, 8'h01);
    chk("lat_seg2_old", {1'b0, o_Segment2}, 8'h01);
    @(negedge CLK);
    chk("lat_seg2_new", {1'b0, o_Segment2}, 8'h4F);

    // Randomized presses, long holds and occasional mid-press resets.
    for (int i = 0; i < 250; i++) begin
      int hi;
      int gap;
      hi  = $urandom_range(1, HOLD + 4);
      gap = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        @(negedge CLK);
        i_Button_State = 1'b1;
        repeat ($urandom_range(0, HOLD + 2)) @(negedge CLK);
        #2 i_Reset = 1'b1;
        @(negedge CLK);
        if ($urandom_range(0, 1) == 1) i_Button_State = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        i_Reset = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge CLK);
        i_Button_State = 1'b0;
      end else begin
        press(hi, gap);
      end
    end
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/press_counter_display.md
PRESS_COUNTER_DISPLAY -- requirements
Module: press_counter_display

Interface
REQ-001 Parameter HOLD_TIME, default 25000000, meaning the number of consecutive pressed cycles that turn a press into a clear; legal range 2..2^25-1.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  reset, asynchronous, active-high.
REQ-004 i_Button_State  input  1  debounced button level, 1 = pressed, synchronous to CLK; the block adds no synchronizer.
REQ-005 o_Count  output  8  current press count, BCD; [7:4] = tens, [3:0] = ones.
REQ-006 o_Segment1  output  7  tens digit, active-low segments; bit6 = A through bit0 = G.
REQ-007 o_Segment2  output  7  ones digit, same encoding as o_Segment1.
REQ-008 o_Cleared  output  1  one-cycle pulse, high the cycle after a long-press clear takes effect.

Function
REQ-009 The FSM SHALL have three states: IDLE, PRESSED and HELD, plus a 25-bit hold timer.
REQ-010 IDLE: i_Button_State=1 SHALL move to PRESSED with timer <= 0; otherwise stay in IDLE.
REQ-011 PRESSED, i_Button_State=0: SHALL increment o_Count at that edge and move to IDLE.
REQ-012 PRESSED, i_Button_State=1, timer == HOLD_TIME-1: SHALL set o_Count <= 8'h00, pulse o_Cleared on the next cycle and move to HELD.
REQ-013 PRESSED, i_Button_State=1, timer < HOLD_TIME-1: SHALL increment the timer.
REQ-014 HELD: SHALL stay until i_Button_State=0, then move to IDLE with no increment.
REQ-015 Release and timer threshold in the same cycle: release SHALL win (increment, go to IDLE, no clear).
REQ-016 Increment SHALL be BCD:
- ones 9 -> 0 with carry into tens;
- 8'h99 -> 8'h00 with no other side effect.
REQ-017 o_Count SHALL change only on a release from PRESSED or on a clear; it SHALL never change in IDLE or HELD.
REQ-018 Latency: a release sampled at edge n SHALL make o_Count valid after edge n; the segment outputs update after edge n+1.
REQ-019 Segment outputs SHALL be registered decodes of o_Count, one cycle behind it.
REQ-020 Segment codes, active-low {A..G}: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04.
REQ-021 A non-BCD digit value SHALL be unreachable; if decoded, it SHALL produce 7'h7F (blank).
REQ-022 A button held at 1 through IDLE -> PRESSED -> HELD SHALL cause exactly one clear and no increment.
REQ-023 o_Cleared SHALL be 0 in every cycle except the single cycle after a clear.

Reset
REQ-024 While i_Reset=1, regardless of CLK, the block SHALL hold: state=IDLE, timer=0, o_Count=8'h00, o_Cleared=0, o_Segment1=o_Segment2=7'h01.
REQ-025 Reset asserted mid-press (PRESSED or HELD) SHALL abandon the press; no increment or clear SHALL occur on release.
REQ-026 After reset deasserts with the button already at 1, the block SHALL enter PRESSED on the first edge and treat the press as a new press.

Verification (HOLD_TIME=8)
REQ-027 Reset, then 3 presses of 2 cycles each with 2-cycle gaps -> o_Count=8'h03, Segment1=7'h01, Segment2=7'h06, o_Cleared never high.
REQ-028 Preload by 99 short presses, then one more press -> o_Count 8'h99 -> 8'h00 on release; Segment1 and Segment2 both 7'h01 one cycle later.
REQ-029 Count 8'h05, then hold 20 cycles -> o_Count=8'h00 after the 8th pressed cycle, o_Cleared high exactly 1 cycle; release causes no increment.
REQ-030 Count 8'h02, then hold exactly 8 cycles with release sampled in the threshold cycle -> o_Count=8'h03, no clear pulse.
REQ-031 Count 8'h04, then assert i_Reset asynchronously mid-PRESSED, deassert, and release -> o_Count=8'h00 immediately at reset assertion and 8'h00 after release.
REQ-032 Press of 1 cycle -> o_Count increments by 1; o_Count changes 1 cycle before the segment outputs.
